id_hazard_scoreboard: RTL and testbench

Parametrised hazard scoreboard for the decode stage. It generalises the single-cycle load-use check to any number of producer latency classes. A per-register countdown table records when each in-flight result can be forwarded. The block drives the PC/IF_ID write-enable stall and the ID_EX control-clear bubble, and honours an external pipeline hold and a decode flush.

---
 rtl/id_hazard_if.sv | 36 +++
 rtl/id_hazard_scoreboard.sv | 106 ++++++++++
 tb/tb_id_hazard_scoreboard.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/id_hazard_if.sv
// id_hazard_if: decode-stage hazard bundle between the ID stage (master) and
// the hazard scoreboard (slave). Carries the decoded instruction's register
// usage, the pipeline hold/flush controls and the stall/bubble/busy answers.
interface id_hazard_if #(
    parameter int AW      = 5,
    parameter int MAX_LAT = 4,
    parameter int CW      = $clog2(MAX_LAT + 1)
);
    logic          id_valid;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic          id_use_rs;
    logic          id_use_rt;
    logic          id_wr_en;
    logic [AW-1:0] id_wr_reg;
    logic [CW-1:0] id_wr_lat;
    logic          hold;
    logic          flush;
    logic          stall;
    logic          bubble;
    logic          sb_busy;

    // Decode stage side: presents the instruction, reads back stall/bubble
    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
        output id_wr_en, id_wr_reg, id_wr_lat, hold, flush,
        input  stall, bubble, sb_busy
    );

    // Scoreboard side
    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
        input  id_wr_en, id_wr_reg, id_wr_lat, hold, flush,
        output stall, bubble, sb_busy
    );
endinterface

// File: rtl/id_hazard_scoreboard.sv
// id_hazard_scoreboard: per-register countdown table for decode-stage RAW
// hazards with multiple producer latency classes. Each entry holds the number
// of cycles a dependent must still wait before the result can be forwarded.
// Optional feature macro: HAZARD_PERF_CNT_EN adds the 32-bit saturating
// stall_cycles performance counter port.
module id_hazard_scoreboard #(
    parameter int AW      = 5,
    parameter int MAX_LAT = 4,
    parameter int CW      = $clog2(MAX_LAT + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    id_hazard_if.slave bus
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles
`endif
);
    localparam int            NREG    = 1 << AW;
    localparam logic [CW-1:0] LAT_MAX = CW'(MAX_LAT);

    logic [CW-1:0] cnt_q [NREG];
    logic [CW-1:0] cnt_d [NREG];
    logic [NREG-1:0] entry_nz;

    logic          rs_pending;
    logic          rt_pending;
    logic          raw;
    logic          issue;
    logic [CW-1:0] lat_clamp;
    logic          stall_int;
    logic          bubble_int;

    // Hazard detection against the pre-issue table, so an instruction that
    // reads and writes the same register is checked against the old count
    always_comb begin
        rs_pending = bus.id_use_rs && (bus.id_rs != '0) && (cnt_q[bus.id_rs] != '0);
        rt_pending = bus.id_use_rt && (bus.id_rt != '0) && (cnt_q[bus.id_rt] != '0);
        raw        = bus.id_valid && (rs_pending || rt_pending);
        // hold outranks flush, flush outranks the hazard
        stall_int  = rst_n && !bus.hold && !bus.flush && raw;
        bubble_int = rst_n && !bus.hold && (bus.flush || raw);
        issue      = bus.id_valid && !bus.hold && !bus.flush && !raw
                     && bus.id_wr_en && (bus.id_wr_reg != '0);
        lat_clamp  = (bus.id_wr_lat > LAT_MAX) ? LAT_MAX : bus.id_wr_lat;
    end

    // Per-entry next count: frozen on hold, otherwise count down; an issuing
    // writer raises its entry but never below what an older producer needs
    for (genvar gi = 0; gi < NREG; gi++) begin : g_entry
        if (gi == 0) begin : g_zero
            assign cnt_d[gi] = '0;
        end else begin : g_reg
            logic [CW-1:0] dec;
            logic          hit;
            assign dec = (cnt_q[gi] != '0) ? (cnt_q[gi] - CW'(1)) : '0;
            assign hit = issue && (bus.id_wr_reg == AW'(gi));
            assign cnt_d[gi] = bus.hold                   ? cnt_q[gi] :
                               (hit && (lat_clamp > dec)) ? lat_clamp :
                                                            dec;
        end
        assign entry_nz[gi] = (cnt_q[gi] != '0);
    end

    // Countdown table register, cleared by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.stall   = stall_int;
    assign bus.bubble  = bubble_int;
    assign bus.sb_busy = rst_n && (|entry_nz);

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] stall_cycles_d;

    // Count stalled, non-held cycles; stick at all-ones instead of wrapping
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_int && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    // Performance counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// tb_id_hazard_scoreboard: directed vector table for id_hazard_scoreboard
// (AW=5, MAX_LAT=4) plus hand-written hold and drain sequences.
// With HAZARD_PERF_CNT_EN defined the stall_cycles counter is checked too.
module tb_id_hazard_scoreboard;
    logic clk;
    logic rst_n;

    id_hazard_if #(.AW(5), .MAX_LAT(4)) bus_if ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles;
`endif

    id_hazard_scoreboard #(.AW(5), .MAX_LAT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst_n;
        logic       valid;
        logic [4:0] rs;
        logic       use_rs;
        logic [4:0] rt;
        logic       use_rt;
        logic       wr_en;
        logic [4:0] wr_reg;
        logic [2:0] wr_lat;
        logic       hold;
        logic       flush;
        logic       e_stall;
        logic       e_bubble;
        logic       e_busy;
    } vec_t;

    vec_t vecs[$];
    int   total;
    int   bad;
    int   exp_sc;

    function automatic vec_t row(int r, int vld, int rs, int urs, int rt, int urt,
                                 int we, int wr, int lat, int h, int f,
                                 int es, int eb, int ebz);
        vec_t v;
        v.rst_n    = r[0];
        v.valid    = vld[0];
        v.rs       = rs[4:0];
        v.use_rs   = urs[0];
        v.rt       = rt[4:0];
        v.use_rt   = urt[0];
        v.wr_en    = we[0];
        v.wr_reg   = wr[4:0];
        v.wr_lat   = lat[2:0];
        v.hold     = h[0];
        v.flush    = f[0];
        v.e_stall  = es[0];
        v.e_bubble = eb[0];
        v.e_busy   = ebz[0];
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst_n            = v.rst_n;
        bus_if.id_valid  = v.valid;
        bus_if.id_rs     = v.rs;
        bus_if.id_use_rs = v.use_rs;
        bus_if.id_rt     = v.rt;
        bus_if.id_use_rt = v.use_rt;
        bus_if.id_wr_en  = v.wr_en;
        bus_if.id_wr_reg = v.wr_reg;
        bus_if.id_wr_lat = v.wr_lat;
        bus_if.hold      = v.hold;
        bus_if.flush     = v.flush;
    endtask

    task automatic chk(input string name, input int idx, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s idx=%0d got=%0d want=%0d", name, idx, got, want);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog idx=0 got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   n_stall;
        int   n_busy;
        logic done;

        total  = 0;
        bad    = 0;
        exp_sc = 0;

        //            rst vld rs urs rt urt we wr lat h f  st bb bz
        // load-use
        vecs.push_back(row(1, 1,  0, 0,  0, 0,  1, 8, 1, 0, 0, 0, 0, 0));
        vecs.push_back(row(1, 1,  8, 1,  0, 0,  0, 0, 0, 0, 0, 1, 1, 1));
        vecs.push_back(row(1, 1,  8, 1,  0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
        // ALU forward
        vecs.push_back(row(1, 1,  0, 0,  0, 0,  1, 9, 0, 0, 0, 0, 0, 0));
        vecs.push_back(row(1, 1,  0, 0,  9, 1,  0, 0, 0, 0, 0, 0, 0, 0));
        // long latency with a 3-cycle hold mid-stall
        vecs.push_back(row(1, 1,  0, 0,  0, 0,  1, 3, 4, 0, 0, 0, 0, 0));
        vecs.push_back(row(1, 1,  3, 1,  0, 0,  0, 0, 0, 0, 0, 1, 1, 1));
        vecs.push_back(row(1, 1,  3, 1,  0, 0,  0, 0, 0, 1, 0, 0, 0, 1));
        vecs.push_back(row(1, 1,  3, 1,  0, 0,  0, 0, 0, 1, 0, 0, 0, 1));
        vecs.push_back(row(1, 1,  3, 1,  0, 0,  0, 0, 0, 1, 0, 0, 0, 1));
        vecs.push_back(row(1, 1,  3, 1,  0, 0,  0, 0, 0, 0, 0, 1, 1, 1));
        vecs.push_back(row(1, 1,  3, 1,  0, 0,  0, 0, 0, 0, 0, 1, 1, 1));
        vecs.push_back(row(1, 1,  3, 1,  0, 0,  0, 0, 0, 0, 0, 1, 1, 1));
        vecs.push_back(row(1, 1,  3, 1,  0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
        // WAW: long then short writer to r5
        vecs.push_back(row(1, 1,  0, 0,  0, 0,  1, 5, 4, 0, 0, 0, 0, 0));
        vecs.push_back(row(1, 1,  0, 0,  0, 0,  1, 5, 0, 0, 0, 0, 0, 1));
        vecs.push_back(row(1, 1,  0, 0,  5, 1,  0, 0, 0, 0, 0, 1, 1, 1));
        vecs.push_back(row(1, 1,  0, 0,  5, 1,  0, 0, 0, 0, 0, 1, 1, 1));
        vecs.push_back(row(1, 1,  0, 0,  5, 1,  0, 0, 0, 0, 0, 1, 1, 1));
        vecs.push_back(row(1, 1,  0, 0,  5, 1,  0, 0, 0, 0, 0, 0, 0, 0));
        // $zero is never tracked
        vecs.push_back(row(1, 1,  0, 0,  0, 0,  1, 0, 4, 0, 0, 0, 0, 0));
        vecs.push_back(row(1, 1,  0, 1,  0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
        // self-dependence checked against the pre-issue count
        vecs.push_back(row(1, 1,  6, 1,  0, 0,  1, 6, 2, 0, 0, 0, 0, 0));
        vecs.push_back(row(1, 1,  6, 1,  0, 0,  1, 6, 2, 0, 0, 1, 1, 1));
        vecs.push_back(row(1, 1,  6, 1,  0, 0,  1, 6, 2, 0, 0, 1, 1, 1));
        vecs.push_back(row(1, 1,  6, 1,  0, 0,  1, 6, 2, 0, 0, 0, 0, 0));
        vecs.push_back(row(1, 0,  6, 1,  0, 0,  0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(row(1, 0,  6, 1,  0, 0,  0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(row(1, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
        // flush of a stalled dependent that would have written r11
        vecs.push_back(row(1, 1,  0, 0,  0, 0,  1, 10, 3, 0, 0, 0, 0, 0));
        vecs.push_back(row(1, 1, 10, 1,  0, 0,  1, 11, 2, 0, 0, 1, 1, 1));
        vecs.push_back(row(1, 1, 10, 1,  0, 0,  1, 11, 2, 0, 1, 0, 1, 1));
        vecs.push_back(row(1, 1, 11, 1,  0, 0,  0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(row(1, 1, 10, 1,  0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
        // flushed writer records nothing
        vecs.push_back(row(1, 1,  0, 0,  0, 0,  1, 12, 4, 0, 1, 0, 1, 0));
        vecs.push_back(row(1, 1, 12, 1,  0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
        // reset mid-operation
        vecs.push_back(row(1, 1,  0, 0,  0, 0,  1, 7, 3, 0, 0, 0, 0, 0));
        vecs.push_back(row(0, 1,  7, 1,  0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(row(1, 1,  7, 1,  0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
        // latency clamp: 7 -> 4
        vecs.push_back(row(1, 1,  0, 0,  0, 0,  1, 4, 7, 0, 0, 0, 0, 0));
        vecs.push_back(row(1, 1,  4, 1,  0, 0,  0, 0, 0, 0, 0, 1, 1, 1));
        vecs.push_back(row(1, 1,  4, 1,  0, 0,  0, 0, 0, 0, 0, 1, 1, 1));
        vecs.push_back(row(1, 1,  4, 1,  0, 0,  0, 0, 0, 0, 0, 1, 1, 1));
        vecs.push_back(row(1, 1,  4, 1,  0, 0,  0, 0, 0, 0, 0, 1, 1, 1));
        vecs.push_back(row(1, 1,  4, 1,  0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
        // hold outranks flush; flush alone bubbles
        vecs.push_back(row(1, 1,  0, 0,  0, 0,  1, 13, 2, 0, 0, 0, 0, 0));
        vecs.push_back(row(1, 1, 13, 1,  0, 0,  0, 0, 0, 1, 1, 0, 0, 1));
        vecs.push_back(row(1, 1, 13, 1,  0, 0,  0, 0, 0, 0, 1, 0, 1, 1));
        vecs.push_back(row(1, 1, 13, 1,  0, 0,  0, 0, 0, 0, 0, 1, 1, 1));
        vecs.push_back(row(1, 1, 13, 1,  0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
        // no issue while held
        vecs.push_back(row(1, 1,  0, 0,  0, 0,  1, 14, 3, 1, 0, 0, 0, 0));
        vecs.push_back(row(1, 1, 14, 1,  0, 0,  0, 0, 0, 0, 0, 0, 0, 0));

        // initial reset for two edges
        drive(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #2;
            $display("row %0d: rst_n=%0b stall=%0b bubble=%0b busy=%0b", i,
                     rst_n, bus_if.stall, bus_if.bubble, bus_if.sb_busy);
            chk("stall",  i, longint'(bus_if.stall),   longint'(vecs[i].e_stall));
            chk("bubble", i, longint'(bus_if.bubble),  longint'(vecs[i].e_bubble));
            chk("busy",   i, longint'(bus_if.sb_busy), longint'(vecs[i].e_busy));
`ifdef HAZARD_PERF_CNT_EN
            chk("stall_cycles", i, longint'(stall_cycles), longint'(exp_sc));
`endif
            if (!vecs[i].rst_n) exp_sc = 0;
            else if (vecs[i].e_stall) exp_sc++;
        end

        // Hold for two cycles inside a 4-cycle stall; unheld stall cycles must total 4
        @(negedge clk);
        drive(row(1, 1, 0, 0, 0, 0, 1, 15, 4, 0, 0, 0, 0, 0));
        n_stall = 0;
        done    = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            drive(row(1, 1, 15, 1, 0, 0, 0, 0, 0, ((c == 1) || (c == 2)) ? 1 : 0, 0, 0, 0, 0));
            #2;
            $display("hold_seq cycle %0d: hold=%0b stall=%0b busy=%0b", c,
                     bus_if.hold, bus_if.stall, bus_if.sb_busy);
            if (bus_if.hold) begin
                chk("hold_stall", c, longint'(bus_if.stall),   0);
                chk("hold_busy",  c, longint'(bus_if.sb_busy), 1);
            end else if (bus_if.stall) begin
                n_stall++;
            end else begin
                done = 1'b1;
            end
        end
        chk("hold_seq_done",  0, longint'(done), 1);
        chk("hold_seq_stall", 0, longint'(n_stall), 4);
        exp_sc = exp_sc + 4;

        // Drain: a latency-3 producer keeps sb_busy up for exactly 3 cycles
        @(negedge clk);
        drive(row(1, 1, 0, 0, 0, 0, 1, 16, 3, 0, 0, 0, 0, 0));
        n_busy = 0;
        done   = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            drive(row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            #2;
            $display("drain cycle %0d: busy=%0b", c, bus_if.sb_busy);
            if (bus_if.sb_busy) n_busy++;
            else done = 1'b1;
        end
        chk("drain_done",   0, longint'(done), 1);
        chk("drain_cycles", 0, longint'(n_busy), 3);

`ifdef HAZARD_PERF_CNT_EN
        chk("stall_cycles_final", 0, longint'(stall_cycles), longint'(exp_sc));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
